// File: rtl/regfile_if.sv
// Register-file access bus: one write-back port and two operand read ports.
//   master : pipeline side, drives write/read requests, receives read data
//   slave  : register file side
// Ports (all in this interface):
//   write_enable/write_addr/write_data  write-back request
//   readN_enable/readN_addr             operand N read request (N = 1, 2)
//   readN_data                          operand N value (combinational)
interface regfile_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  write_enable;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  read1_enable;
  logic [ADDR_WIDTH-1:0] read1_addr;
  logic [DATA_WIDTH-1:0] read1_data;
  logic                  read2_enable;
  logic [ADDR_WIDTH-1:0] read2_addr;
  logic [DATA_WIDTH-1:0] read2_data;

  modport master (
    output write_enable, write_addr, write_data,
    output read1_enable, read1_addr, read2_enable, read2_addr,
    input  read1_data, read2_data
  );

  modport slave (
    input  write_enable, write_addr, write_data,
    input  read1_enable, read1_addr, read2_enable, read2_addr,
    output read1_data, read2_data
  );
endinterface

// File: rtl/regfile.sv
// Architectural register file, REG_COUNT x DATA_WIDTH, r0 hard-wired to zero.
// One synchronous write port, two combinational read ports with
// read-during-write bypass so a same-cycle consumer sees the new value.
// Ports:
//   clock  rising-edge clock
//   reset  synchronous active-high; clears storage, forces read data to 0
//   bus    regfile_if.slave (write port + two read ports)

// One read port: gating, r0 masking and write bypass.
module regfile_rd_port #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int REG_COUNT  = 32
) (
  input  logic                                 reset,
  input  logic                                 rd_en,
  input  logic [ADDR_WIDTH-1:0]                rd_addr,
  input  logic [REG_COUNT-1:0][DATA_WIDTH-1:0] regs,
  input  logic                                 wr_en,
  input  logic [ADDR_WIDTH-1:0]                wr_addr,
  input  logic [DATA_WIDTH-1:0]                wr_data,
  output logic [DATA_WIDTH-1:0]                rd_data
);
  always_comb begin
    rd_data = '0;
    // r0 is masked here as well as never written, so a bypass to r0 can't leak
    if (!reset && rd_en && (rd_addr != '0)) begin
      if (wr_en && (wr_addr == rd_addr))
        rd_data = wr_data;
      else
        rd_data = regs[rd_addr];
    end
  end
endmodule

module regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int REG_COUNT  = 32
) (
  input logic      clock,
  input logic      reset,
  regfile_if.slave bus
);
  localparam int NUM_RD = 2;

  logic [REG_COUNT-1:0][DATA_WIDTH-1:0] regs;

  logic [NUM_RD-1:0]                 rd_en;
  logic [NUM_RD-1:0][ADDR_WIDTH-1:0] rd_addr;
  logic [NUM_RD-1:0][DATA_WIDTH-1:0] rd_data;

  // Reset wins over a coincident write.
  always_ff @(posedge clock) begin
    if (reset)
      regs <= '0;
    else if (bus.write_enable && (bus.write_addr != '0))
      regs[bus.write_addr] <= bus.write_data;
  end

  assign rd_en   = {bus.read2_enable, bus.read1_enable};
  assign rd_addr = {bus.read2_addr,   bus.read1_addr};

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    regfile_rd_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .REG_COUNT  (REG_COUNT)
    ) u_rd (
      .reset   (reset),
      .rd_en   (rd_en[g]),
      .rd_addr (rd_addr[g]),
      .regs    (regs),
      .wr_en   (bus.write_enable),
      .wr_addr (bus.write_addr),
      .wr_data (bus.write_data),
      .rd_data (rd_data[g])
    );
  end

  assign bus.read1_data = rd_data[0];
  assign bus.read2_data = rd_data[1];
endmodule
